// File: rtl/job_ctrl_pkg.sv
// Shared types and helpers for the job-control FSM: state encoding, datapath
// widths and the busy-state decode.
package job_ctrl_pkg;

  localparam int COUNTER_W = 8;
  localparam int LEN_W     = 8;
  localparam int TIMER_W   = 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'b000,
    S_WAIT   = 3'b001,
    S_ACTIVE = 3'b010,
    S_PROC   = 3'b011,
    S_DONE   = 3'b100,
    S_ERROR  = 3'b101
  } state_e;

  function automatic logic is_busy(input state_e s);
    return (s == S_WAIT) || (s == S_ACTIVE) || (s == S_PROC);
  endfunction

endpackage

// File: rtl/job_ctrl_timer.sv
// Small up-counter with synchronous clear and a terminal-count compare.
// Used for the WAIT grant timeout and the ERROR auto-recovery delay.
module job_ctrl_timer
  import job_ctrl_pkg::*;
#(
  parameter logic [TIMER_W-1:0] TERMINAL = 8'd15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output logic at_tc
);

  logic [TIMER_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  assign at_tc = (count == TERMINAL);

endmodule

// File: rtl/job_ctrl_fsm.sv
// Job-control FSM: accepts a job, waits for a resource grant, processes len
// items one per cycle and reports DONE or ERROR. All outputs come from registers.
module job_ctrl_fsm
  import job_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_TIMEOUT = 16,
  parameter int unsigned RECOV_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 fast,
  input  logic [LEN_W-1:0]     len,
  input  logic                 grant,
  input  logic                 more,
  input  logic                 fault,
  input  logic                 clear,
  output logic [2:0]           state,
  output logic [COUNTER_W-1:0] counter,
  output logic                 busy,
  output logic                 done,
  output logic                 error_flag,
  output logic                 req
);

  state_e               state_q, state_d;
  logic [LEN_W-1:0]     rem_q;
  logic [COUNTER_W-1:0] counter_q;
  logic                 error_flag_q;
  logic                 wait_tc, recov_tc;
  logic                 accept_start, proc_item, err_clear, enter_error;

  // Timers are held at zero outside their state, so each entry starts from 0.
  job_ctrl_timer #(.TERMINAL(TIMER_W'(WAIT_TIMEOUT - 1))) u_wait_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (state_q != S_WAIT),
    .inc   (state_q == S_WAIT),
    .at_tc (wait_tc)
  );

  job_ctrl_timer #(.TERMINAL(TIMER_W'(RECOV_CYCLES - 1))) u_recov_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (state_q != S_ERROR),
    .inc   (state_q == S_ERROR),
    .at_tc (recov_tc)
  );

  assign accept_start = (state_q == S_IDLE) && start;
  assign proc_item    = (state_q == S_PROC) && !fault;
  assign err_clear    = (state_q == S_ERROR) && clear;
  assign enter_error  = (state_d == S_ERROR) && (state_q != S_ERROR);

  // NOTE: the default assignment before the case keeps state_d fully
  // assigned on every path, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len == '0)   state_d = S_DONE;
          else if (fast)   state_d = S_ACTIVE;
          else             state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (fault)        state_d = S_ERROR;
        else if (grant)   state_d = S_ACTIVE;
        else if (wait_tc) state_d = S_ERROR;
      end
      S_ACTIVE: begin
        if (fault)        state_d = S_ERROR;
        else if (more)    state_d = S_WAIT;
        else if (grant)   state_d = S_PROC;
      end
      S_PROC: begin
        if (fault)                      state_d = S_ERROR;
        else if (rem_q == LEN_W'(1))    state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      S_ERROR: begin
        if (clear)         state_d = S_IDLE;
        else if (recov_tc) state_d = S_DONE;
      end
      default: state_d = S_ERROR;  // 110/111 are unreachable but recoverable
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rem_q        <= '0;
      counter_q    <= '0;
      error_flag_q <= 1'b0;
    end else begin
      state_q <= state_d;

      if (accept_start)   rem_q <= len;
      else if (proc_item) rem_q <= rem_q - 1'b1;

      // clear wins over a same-cycle item so software sees a clean zero.
      if (clear)          counter_q <= '0;
      else if (proc_item) counter_q <= counter_q + 1'b1;

      if (enter_error)                    error_flag_q <= 1'b1;
      else if (accept_start || err_clear) error_flag_q <= 1'b0;
    end
  end

  assign state      = state_q;
  assign counter    = counter_q;
  assign error_flag = error_flag_q;
  assign busy       = is_busy(state_q);
  assign done       = (state_q == S_DONE);
  assign req        = (state_q == S_WAIT);

endmodule

// File: tb/tb_job_ctrl_fsm.sv
// Directed bench for job_ctrl_fsm: one task per scenario, each comparing
// observed outputs against hand-derived values.
module tb_job_ctrl_fsm;

  localparam logic [2:0] IDLE   = 3'b000;
  localparam logic [2:0] WAIT   = 3'b001;
  localparam logic [2:0] ACTIVE = 3'b010;
  localparam logic [2:0] PROC   = 3'b011;
  localparam logic [2:0] DONE   = 3'b100;
  localparam logic [2:0] ERROR  = 3'b101;

  logic       clk, rst, start, fast, grant, more, fault, clear;
  logic [7:0] len;
  logic [2:0] state;
  logic [7:0] counter;
  logic       busy, done, error_flag, req;

  int total = 0;
  int bad   = 0;

  job_ctrl_fsm #(.WAIT_TIMEOUT(16), .RECOV_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .fast       (fast),
    .len        (len),
    .grant      (grant),
    .more       (more),
    .fault      (fault),
    .clear      (clear),
    .state      (state),
    .counter    (counter),
    .busy       (busy),
    .done       (done),
    .error_flag (error_flag),
    .req        (req)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected {busy, done, req} for a given state.
  function automatic logic [2:0] exp_flags(input logic [2:0] s);
    logic b;
    b = (s == WAIT) || (s == ACTIVE) || (s == PROC);
    return {b, s == DONE, s == WAIT};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 0; fast = 0; len = '0; grant = 0; more = 0; fault = 0; clear = 0;
    step(); step();
    total++;
    if (state !== IDLE) begin bad++; $display("FAIL reset_state: got %b want %b", state, IDLE); end
    total++;
    if (counter !== 8'd0 || error_flag !== 1'b0) begin
      bad++; $display("FAIL reset_regs: counter=%0d err=%b want 0/0", counter, error_flag);
    end
    total++;
    if ({busy, done, req} !== 3'b000) begin
      bad++; $display("FAIL reset_flags: got %b want 000", {busy, done, req});
    end
    rst = 1'b0;
    step();
    total++;
    if (state !== IDLE) begin bad++; $display("FAIL reset_release: got %b want %b", state, IDLE); end
  endtask

  logic [2:0] t1_state [8] = '{WAIT, WAIT, ACTIVE, PROC, PROC, PROC, DONE, IDLE};
  logic       t1_grant [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  task automatic test_basic_job();
    int done_cnt = 0;
    len = 8'd3; fast = 0;
    for (int i = 0; i < 8; i++) begin
      start = (i == 0);
      grant = t1_grant[i];
      step();
      done_cnt += int'(done);
      total++;
      if (state !== t1_state[i]) begin
        bad++; $display("FAIL basic_state[%0d]: got %b want %b", i, state, t1_state[i]);
      end
      total++;
      if ({busy, done, req} !== exp_flags(t1_state[i])) begin
        bad++; $display("FAIL basic_flags[%0d]: got %b want %b", i, {busy, done, req}, exp_flags(t1_state[i]));
      end
    end
    start = 0; grant = 0;
    total++;
    if (counter !== 8'd3) begin bad++; $display("FAIL basic_counter: got %0d want 3", counter); end
    total++;
    if (done_cnt != 1) begin bad++; $display("FAIL basic_done_pulse: got %0d cycles want 1", done_cnt); end
  endtask

  task automatic test_empty_job();
    start = 1; fast = 1; len = 8'd0;
    step();
    start = 0; fast = 0;
    total++;
    if (state !== DONE || busy !== 1'b0) begin
      bad++; $display("FAIL empty_done: state=%b busy=%b want %b/0", state, busy, DONE);
    end
    step();
    total++;
    if (state !== IDLE || busy !== 1'b0) begin
      bad++; $display("FAIL empty_idle: state=%b busy=%b want %b/0", state, busy, IDLE);
    end
    total++;
    if (counter !== 8'd3) begin bad++; $display("FAIL empty_counter: got %0d want 3", counter); end
  endtask

  task automatic test_wait_timeout();
    start = 1; fast = 0; len = 8'd5;
    step();
    start = 0;
    for (int i = 1; i <= 15; i++) begin
      step();
      total++;
      if (state !== WAIT) begin bad++; $display("FAIL timeout_wait[%0d]: got %b want %b", i, state, WAIT); end
    end
    step();
    total++;
    if (state !== ERROR || error_flag !== 1'b1) begin
      bad++; $display("FAIL timeout_error: state=%b err=%b want %b/1", state, error_flag, ERROR);
    end
    for (int i = 1; i <= 3; i++) begin
      step();
      total++;
      if (state !== ERROR) begin bad++; $display("FAIL recov_hold[%0d]: got %b want %b", i, state, ERROR); end
    end
    step();
    total++;
    if (state !== DONE || error_flag !== 1'b1) begin
      bad++; $display("FAIL recov_done: state=%b err=%b want %b/1", state, error_flag, DONE);
    end
    step();
    total++;
    if (state !== IDLE || error_flag !== 1'b1) begin
      bad++; $display("FAIL recov_idle: state=%b err=%b want %b/1", state, error_flag, IDLE);
    end
    start = 1; fast = 1; len = 8'd1;
    step();
    start = 0; fast = 0;
    total++;
    if (state !== ACTIVE || error_flag !== 1'b0) begin
      bad++; $display("FAIL restart_clears_err: state=%b err=%b want %b/0", state, error_flag, ACTIVE);
    end
    grant = 1; step(); grant = 0;
    step();
    total++;
    if (state !== DONE || counter !== 8'd4) begin
      bad++; $display("FAIL restart_job: state=%b counter=%0d want %b/4", state, counter, DONE);
    end
    step();
  endtask

  task automatic test_fault_clear();
    clear = 1; step(); clear = 0;
    total++;
    if (state !== IDLE || counter !== 8'd0) begin
      bad++; $display("FAIL idle_clear: state=%b counter=%0d want %b/0", state, counter, IDLE);
    end
    start = 1; fast = 1; len = 8'd5;
    step();
    start = 0; fast = 0;
    grant = 1; step(); grant = 0;
    step(); step();
    fault = 1; step(); fault = 0;
    total++;
    if (state !== ERROR || counter !== 8'd2 || error_flag !== 1'b1) begin
      bad++; $display("FAIL proc_fault: state=%b counter=%0d err=%b want %b/2/1", state, counter, error_flag, ERROR);
    end
    clear = 1; step(); clear = 0;
    total++;
    if (state !== IDLE || error_flag !== 1'b0 || counter !== 8'd0) begin
      bad++; $display("FAIL error_clear: state=%b err=%b counter=%0d want %b/0/0", state, error_flag, counter, IDLE);
    end
  endtask

  task automatic test_counter_wrap();
    logic [7:0] exp_cnt;
    start = 1; fast = 1; len = 8'd250;
    step();
    start = 0; fast = 0;
    grant = 1; step(); grant = 0;
    repeat (250) step();
    total++;
    if (state !== DONE || counter !== 8'd250) begin
      bad++; $display("FAIL preload: state=%b counter=%0d want %b/250", state, counter, DONE);
    end
    step();
    start = 1; fast = 1; len = 8'd10;
    step();
    start = 0; fast = 0;
    grant = 1; step(); grant = 0;
    exp_cnt = 8'd250;
    for (int i = 1; i <= 10; i++) begin
      step();
      exp_cnt = exp_cnt + 8'd1;
      total++;
      if (counter !== exp_cnt || state !== ((i == 10) ? DONE : PROC)) begin
        bad++; $display("FAIL wrap[%0d]: counter=%0d state=%b want %0d/%b", i, counter, state, exp_cnt,
                        (i == 10) ? DONE : PROC);
      end
    end
    step();
  endtask

  task automatic test_simultaneous();
    fault = 1; step(); fault = 0;
    total++;
    if (state !== IDLE || error_flag !== 1'b0) begin
      bad++; $display("FAIL idle_fault_ignored: state=%b err=%b want %b/0", state, error_flag, IDLE);
    end
    start = 1; len = 8'd1;
    step();
    start = 0;
    fault = 1; grant = 1; step(); fault = 0; grant = 0;
    total++;
    if (state !== ERROR) begin bad++; $display("FAIL wait_fault_grant: got %b want %b", state, ERROR); end
    clear = 1; step(); clear = 0;
    total++;
    if (state !== IDLE || counter !== 8'd0) begin
      bad++; $display("FAIL sim_clear: state=%b counter=%0d want %b/0", state, counter, IDLE);
    end
  endtask

  task automatic test_more_and_reset();
    start = 1; fast = 0; len = 8'd2;
    step();
    start = 0;
    grant = 1; step();
    more = 1; step(); more = 0;
    total++;
    if (state !== WAIT) begin bad++; $display("FAIL more_grant: got %b want %b", state, WAIT); end
    step();
    grant = 0;
    total++;
    if (state !== ACTIVE) begin bad++; $display("FAIL regrant: got %b want %b", state, ACTIVE); end
    for (int i = 1; i <= 10; i++) begin
      step();
      total++;
      if (state !== ACTIVE) begin bad++; $display("FAIL active_hold[%0d]: got %b want %b", i, state, ACTIVE); end
    end
    grant = 1; step(); grant = 0;
    step();
    total++;
    if (state !== PROC || counter !== 8'd1) begin
      bad++; $display("FAIL pre_reset: state=%b counter=%0d want %b/1", state, counter, PROC);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (state !== IDLE || counter !== 8'd0) begin
      bad++; $display("FAIL async_reset: state=%b counter=%0d want %b/0", state, counter, IDLE);
    end
    step();
    rst = 1'b0;
    step();
    total++;
    if (state !== IDLE || done !== 1'b0) begin
      bad++; $display("FAIL post_reset: state=%b done=%b want %b/0", state, done, IDLE);
    end
  endtask

  initial begin
    test_reset();
    test_basic_job();
    test_empty_job();
    test_wait_timeout();
    test_fault_clear();
    test_counter_wrap();
    test_simultaneous();
    test_more_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
